// File: rtl/serial_frame_assembler_if.sv
// Serial-in / word-out bundle for serial_frame_assembler.
//   bit_valid, s_in, sof : serial bit stream (LSB of each sample first), sof marks frame start
//   word_valid/ready     : handshake on the sample FIFO head
//   word_data/idx/last   : sample value, position in frame, last-of-frame flag
// master: the stream source / word sink side. slave: the assembler.
interface serial_frame_assembler_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned IDX_W = 3
);
    logic             bit_valid;
    logic             s_in;
    logic             sof;
    logic             word_valid;
    logic             word_ready;
    logic [WIDTH-1:0] word_data;
    logic [IDX_W-1:0] word_idx;
    logic             word_last;

    modport master (
        output bit_valid, s_in, sof, word_ready,
        input  word_valid, word_data, word_idx, word_last
    );

    modport slave (
        input  bit_valid, s_in, sof, word_ready,
        output word_valid, word_data, word_idx, word_last
    );
endinterface

// File: rtl/serial_frame_assembler.sv
// Serial frame assembler: collects LSB-first serial bits into WIDTH-bit samples, tags each with
// its position in a POINTS-sample frame and queues it in a 2-entry FIFO for the FFT input buffer.
// Ports:
//   clk      : rising-edge clock
//   clr_n    : synchronous active-low reset
//   bus      : serial_frame_assembler_if.slave (bit stream in, indexed samples out)
//   sync_err : one-cycle pulse when sof interrupts a partial sample or frame
//   overflow : sticky, a completed sample was dropped because the FIFO was full
module serial_frame_assembler #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned POINTS = 8,
    parameter int unsigned IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     clr_n,
    serial_frame_assembler_if.slave  bus,
    output logic                     sync_err,
    output logic                     overflow
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IdxLast = IDX_W'(POINTS - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } entry_t;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sync_err_q, sync_err_d;
    logic             overflow_q, overflow_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] shifted;
    entry_t           push_entry;

    // New bit enters at the MSB so the first bit of a sample ends up at bit 0.
    assign shifted    = {bus.s_in, shift_q[WIDTH-1:1]};
    assign push_entry = '{data: shifted, idx: idx_q, last: (idx_q == IdxLast)};
    assign pop        = (count_q != 2'd0) && bus.word_ready;

    // Assembly FSM: next state, counters and push request.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        sync_err_d = 1'b0;
        push       = 1'b0;
        if (bus.bit_valid) begin
            if (bus.sof) begin
                // ACTIVE always means a partial sample or frame is in flight.
                sync_err_d = (state_q == StActive);
                state_d    = StActive;
                shift_d    = shifted;
                cnt_d      = CNT_W'(1);
                idx_d      = '0;
            end else if (state_q == StActive) begin
                shift_d = shifted;
                if (cnt_q == CntLast) begin
                    push  = 1'b1;
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IdxLast) begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Two-entry FIFO with registered head; a push into a full FIFO succeeds only alongside a pop.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = push_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = push_entry;
                end else if (push) begin
                    tail_d  = push_entry;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_entry;
                    end else begin
                        count_d = 2'd1;
                    end
                end else if (push) begin
                    overflow_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            sync_err_q <= 1'b0;
            overflow_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sync_err_q <= sync_err_d;
            overflow_q <= overflow_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    assign bus.word_valid = (count_q != 2'd0);
    assign bus.word_data  = head_q.data;
    assign bus.word_idx   = head_q.idx;
    assign bus.word_last  = head_q.last;
    assign sync_err       = sync_err_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_serial_frame_assembler.sv
module tb_serial_frame_assembler;
    localparam int unsigned WIDTH  = 4;
    localparam int unsigned POINTS = 8;
    localparam int unsigned IDX_W  = 3;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [IDX_W-1:0] idx;
        logic             last;
    } word_t;

    typedef struct {
        logic             bv;
        logic             s;
        logic             sf;
        logic             rdy;
        logic             e_valid;
        logic [WIDTH-1:0] e_data;
        logic [IDX_W-1:0] e_idx;
        logic             e_sync;
    } vec_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic sync_err;
    logic overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state: queue of collected bits, frame position, FIFO queue.
    word_t mq[$];
    logic  m_bits[$];
    bit    m_active;
    int    m_idx;
    bit    m_ovf;
    bit    m_sync;

    // Words observed leaving the DUT (valid & ready at an edge).
    word_t got[$];

    vec_t vecs[12];

    serial_frame_assembler_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

    serial_frame_assembler #(
        .WIDTH (WIDTH),
        .POINTS(POINTS),
        .IDX_W (IDX_W)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .bus     (bus),
        .sync_err(sync_err),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic bv, input logic s, input logic sf, input logic rdy,
                              input logic rst_n);
        bit    do_push;
        bit    pop;
        word_t w;
        int    val;
        do_push = 0;
        w = '0;
        if (!rst_n) begin
            mq.delete();
            m_bits.delete();
            m_active = 0;
            m_idx = 0;
            m_ovf = 0;
            m_sync = 0;
            return;
        end
        pop = (mq.size() != 0) && rdy;
        m_sync = 0;
        if (bv) begin
            if (sf) begin
                m_sync = m_active;
                m_active = 1;
                m_bits.delete();
                m_bits.push_back(s);
                m_idx = 0;
            end else if (m_active) begin
                m_bits.push_back(s);
                if (m_bits.size() == WIDTH) begin
                    val = 0;
                    for (int i = 0; i < int'(WIDTH); i++) val += int'(m_bits[i]) << i;
                    w.data = WIDTH'(val);
                    w.idx = IDX_W'(m_idx);
                    w.last = (m_idx == POINTS - 1);
                    do_push = 1;
                    m_bits.delete();
                    if (m_idx == POINTS - 1) m_active = 0;
                    m_idx = (m_idx + 1) % POINTS;
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (do_push) begin
            if (mq.size() < 2) mq.push_back(w);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_model();
        check("model_valid", bus.word_valid, (mq.size() != 0));
        if (mq.size() != 0) begin
            check("model_data", bus.word_data, mq[0].data);
            check("model_idx", bus.word_idx, mq[0].idx);
            check("model_last", bus.word_last, mq[0].last);
        end
        check("model_sync_err", sync_err, m_sync);
        check("model_overflow", overflow, m_ovf);
    endtask

    // One clock: drive inputs, log any handshake, clock, advance the model, compare after the edge.
    task automatic cycle(input logic bv, input logic s, input logic sf, input logic rdy,
                         input logic rst_n);
        bus.bit_valid  = bv;
        bus.s_in       = s;
        bus.sof        = sf;
        bus.word_ready = rdy;
        clr_n          = rst_n;
        if (rst_n && bus.word_valid && rdy) begin
            got.push_back('{data: bus.word_data, idx: bus.word_idx, last: bus.word_last});
        end
        @(posedge clk);
        model_step(bv, s, sf, rdy, rst_n);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        got.delete();
    endtask

    task automatic send_sample(input logic [WIDTH-1:0] value, input logic with_sof,
                               input logic rdy);
        for (int b = 0; b < int'(WIDTH); b++) begin
            cycle(1'b1, value[b], with_sof && (b == 0), rdy, 1'b1);
        end
    endtask

    initial begin
        bus.bit_valid  = 1'b0;
        bus.s_in       = 1'b0;
        bus.sof        = 1'b0;
        bus.word_ready = 1'b0;

        // Reset state.
        do_reset();
        check("rst_valid", bus.word_valid, 0);
        check("rst_data", bus.word_data, 0);
        check("rst_idx", bus.word_idx, 0);
        check("rst_last", bus.word_last, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_overflow", overflow, 0);

        // Basic sample 1,0,1,1 -> 0xD, then resync mid-sample with 0,1,1,0 -> 0x6.
        //          bv s  sof rdy  valid data idx sync
        vecs[0]  = '{1, 1, 1, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 1, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 0, 1, 0, 0, 0, 0};
        vecs[3]  = '{1, 1, 0, 1, 1, 4'hD, 0, 0};
        vecs[4]  = '{1, 0, 0, 1, 0, 0, 0, 0};
        vecs[5]  = '{1, 1, 0, 1, 0, 0, 0, 0};
        vecs[6]  = '{1, 0, 1, 1, 0, 0, 0, 1};
        vecs[7]  = '{1, 1, 0, 1, 0, 0, 0, 0};
        vecs[8]  = '{1, 1, 0, 1, 0, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 1, 4'h6, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 1, 4'h6, 0, 0};
        vecs[11] = '{0, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].bv, vecs[i].s, vecs[i].sf, vecs[i].rdy, 1'b1);
            check($sformatf("vec%0d_valid", i), bus.word_valid, vecs[i].e_valid);
            check($sformatf("vec%0d_sync_err", i), sync_err, vecs[i].e_sync);
            if (vecs[i].e_valid) begin
                check($sformatf("vec%0d_data", i), bus.word_data, vecs[i].e_data);
                check($sformatf("vec%0d_idx", i), bus.word_idx, vecs[i].e_idx);
                check($sformatf("vec%0d_last", i), bus.word_last, 0);
            end
        end

        // Full frame: samples 0..7, then 4 bits without sof must be ignored.
        do_reset();
        for (int v = 0; v < int'(POINTS); v++) send_sample(WIDTH'(v), (v == 0), 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("frame_count", got.size(), POINTS);
        for (int k = 0; k < got.size(); k++) begin
            check($sformatf("frame%0d_data", k), got[k].data, k);
            check($sformatf("frame%0d_idx", k), got[k].idx, k);
            check($sformatf("frame%0d_last", k), got[k].last, (k == POINTS - 1));
        end
        got.delete();
        for (int b = 0; b < int'(WIDTH); b++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("idle_no_words", got.size(), 0);
        check("idle_valid", bus.word_valid, 0);

        // Back-pressure for a whole frame: first two samples held, third drops.
        do_reset();
        send_sample(4'd0, 1'b1, 1'b0);
        send_sample(4'd1, 1'b0, 1'b0);
        check("bp_ovf_before", overflow, 0);
        send_sample(4'd2, 1'b0, 1'b0);
        check("bp_ovf_after", overflow, 1);
        for (int v = 3; v < int'(POINTS); v++) send_sample(WIDTH'(v), 1'b0, 1'b0);
        check("bp_head_valid", bus.word_valid, 1);
        check("bp_head_data", bus.word_data, 0);
        check("bp_head_idx", bus.word_idx, 0);
        got.delete();
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("bp_drain_count", got.size(), 2);
        if (got.size() == 2) begin
            check("bp_drain0", got[0].data, 0);
            check("bp_drain1", got[1].data, 1);
        end
        check("bp_drained_valid", bus.word_valid, 0);
        check("bp_ovf_sticky", overflow, 1);

        // Push into full FIFO with a simultaneous pop: nothing dropped.
        do_reset();
        send_sample(4'd0, 1'b1, 1'b0);
        send_sample(4'd1, 1'b0, 1'b0);
        got.delete();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("pp_overflow", overflow, 0);
        for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("pp_count", got.size(), 3);
        for (int k = 0; k < got.size(); k++) begin
            check($sformatf("pp%0d_data", k), got[k].data, k);
            check($sformatf("pp%0d_idx", k), got[k].idx, k);
        end

        // Reset after 6 bits with one word queued.
        do_reset();
        send_sample(4'd5, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("mid_queued", bus.word_valid, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_rst_valid", bus.word_valid, 0);
        check("mid_rst_overflow", overflow, 0);
        got.delete();
        for (int b = 0; b < int'(WIDTH); b++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("mid_no_words", got.size(), 0);
        check("mid_valid", bus.word_valid, 0);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic bv, s, sf, rdy, rn;
            bv  = ($urandom_range(0, 3) != 0);
            s   = 1'($urandom);
            sf  = ($urandom_range(0, 24) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            rn  = ($urandom_range(0, 399) != 0);
            cycle(bv, s, sf, rdy, rn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_frame_assembler.md
Name: serial_frame_assembler

Overview:
- Consumes the serial bit stream that feeds the SIPO shift stage and turns it into indexed parallel samples for the FFT input buffer.
- Bits arrive LSB first. Every WIDTH accepted bits form one sample. Every POINTS samples form one frame, aligned by a start-of-frame strobe.
- Completed samples go into a 2-entry output FIFO with a valid/ready handshake, so downstream back-pressure does not stall the serial side.

Parameters:
- WIDTH, 4, bits per sample (>=2).
- POINTS, 8, samples per FFT frame (power of 2, >=2).
- IDX_W, 3, width of sample index, equal to log2(POINTS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr_n  input  1  synchronous active-low reset, sampled on rising clk edge.
- bit_valid  input  1  s_in carries a valid bit this cycle.
- s_in  input  1  serial data bit, LSB of each sample first.
- sof  input  1  start of frame; meaningful only with bit_valid=1; marks bit 0 of sample 0.
- word_valid  output  1  FIFO head holds a sample.
- word_ready  input  1  downstream accepts the head this cycle.
- word_data  output  WIDTH  sample value at FIFO head.
- word_idx  output  IDX_W  sample position in frame at FIFO head.
- word_last  output  1  head is sample POINTS-1 of its frame.
- sync_err  output  1  one-cycle pulse: sof arrived with a partial sample or partial frame in progress.
- overflow  output  1  sticky: a completed sample was dropped because the FIFO was full.

Behaviour:
- Reset (clr_n=0 at an edge):
  - State goes to IDLE; bit counter, sample index and shift register clear; FIFO empties.
  - word_valid, word_data, word_idx, word_last, sync_err and overflow all read 0.
  - Reset mid-frame discards the partial sample, the frame position and FIFO contents.
- FSM states: IDLE, ACTIVE.
  - IDLE: bits without sof are ignored. bit_valid & sof → ACTIVE, that bit becomes bit 0, bit count=1, sample index=0.
  - ACTIVE: each bit_valid shifts s_in in at the MSB and shifts right, so after WIDTH bits the first-received bit sits at bit 0.
  - ACTIVE, on the WIDTH-th bit: sample completes and is pushed with the current index; last = (index==POINTS-1); bit count returns to 0; index increments.
  - After pushing index POINTS-1 → IDLE.
  - sof while ACTIVE (bit count≠0 or index≠0): partial data discarded; sync_err pulses the next cycle; restart as in the IDLE sof case (same cycle, the sof bit is kept as bit 0).
  - sof coinciding exactly with bit 0 of sample 0 while ACTIVE is impossible, since the FSM is then in IDLE.
- bit_valid=0 holds all assembly state, with no timeout.
- Latency: a completed sample appears at the FIFO head (word_valid=1) in the cycle after the clock edge that captured its WIDTH-th bit, provided the FIFO was empty.
- FIFO: 2 entries; the head is registered.
  - Pop occurs when word_valid & word_ready.
  - Push is accepted if count<2, or if count==2 and a pop occurs in the same cycle.
  - Otherwise the sample is dropped, overflow sets and holds until reset, and the frame index still advances.
  - word_data, word_idx and word_last stay stable while word_valid=1 and word_ready=0.
  - When empty, the head outputs hold their last value; benches must not check them.
- No arithmetic beyond counters. The index wraps naturally at POINTS and the bit counter runs mod WIDTH.

Test Plan:
- Basic sample (WIDTH=4, POINTS=8, word_ready=1): sof with bits 1,0,1,1 on consecutive cycles → next cycle word_valid=1, word_data=4'hD, word_idx=0, word_last=0.
- Full frame: sof then 32 bits encoding samples 0..7 as values 0..7 → eight words, idx 0..7, data 0..7, word_last only on idx 7; FSM returns to IDLE, and 4 further bits without sof produce no word.
- Back-pressure: word_ready=0 for a full frame → first two samples held (data 0,1), overflow=1 after third completes. Then word_ready=1 → pops 0,1 in order, word_valid falls.
- Simultaneous push/pop at full: FIFO holds 2 and a sample completes in the same cycle word_ready=1 → no drop, overflow stays 0, ordering preserved.
- Resync: sof, 2 bits, then sof with bits 0,1,1,0 → sync_err pulse one cycle, next word data=4'h6, idx=0.
- Reset mid-operation: clr_n=0 for one edge after 6 bits with one word queued → word_valid=0 and overflow=0 the next cycle; the next 4 bits without sof produce nothing.
